// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 framing constants and enums, imported by both the transmitter and the receive checker.
package tlk2711_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D11_5 = 8'hAB;

  // 18-bit words are {rkmsb, rklsb, rxd[15:0]}; only the low byte carries a K code.
  localparam logic [17:0] COMMA_WORD = {2'b01, D5_6, K28_5};
  localparam logic [17:0] SOF_WORD   = {2'b01, D11_5, K28_5};

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_ALIGN,
    ST_PAYLOAD
  } rx_state_t;

  typedef enum logic [1:0] {
    WC_COMMA,
    WC_SOF,
    WC_DATA,
    WC_BAD
  } word_class_t;

  function automatic logic [17:0] data_word(input logic [7:0] n);
    return {2'b00, n, n};
  endfunction

endpackage

// File: rtl/tlk2711_word_classify.sv
// Combinational classifier for one received 18-bit word against the framing alphabet
// and the payload word expected at the current index.
module tlk2711_word_classify
  import tlk2711_pkg::*;
(
  input  logic [17:0]  word,
  input  logic [7:0]   idx,
  output word_class_t  word_class,
  output logic         data_match
);

  always_comb begin
    word_class = WC_BAD;
    if (word == COMMA_WORD)
      word_class = WC_COMMA;
    else if (word == SOF_WORD)
      word_class = WC_SOF;
    else if (word[17:16] == 2'b00 && word[15:8] == word[7:0])
      word_class = WC_DATA;
  end

  assign data_match = (word == data_word(idx));

endmodule

// File: rtl/tlk2711_rx_checker.sv
// TLK2711 receive frame checker: locks on comma/SOF framing, checks incrementing payloads,
// tracks sync and counts. Define TLK2711_RX_ERR_LOG_EN to build the first-error log.
module tlk2711_rx_checker
  import tlk2711_pkg::*;
#(
  parameter int DATA_WORDS  = 32,
  parameter int SYNC_FRAMES = 2,
  parameter int LOSS_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_clear,
  input  logic        i_rkmsb,
  input  logic        i_rklsb,
  input  logic [15:0] i_rxd,
  output logic        o_sync,
  output logic        o_frame_done,
  output logic        o_err,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_err_cnt,
  output logic [17:0] o_err_word,
  output logic [17:0] o_err_exp,
  output logic [7:0]  o_err_idx
);

  localparam logic [7:0] LAST_IDX = 8'(DATA_WORDS - 1);

  logic [17:0] word_q;
  logic        enable_q;
  logic        clear_q;
  rx_state_t   state, state_nx;
  logic [7:0]  idx, idx_nx;
  logic [7:0]  good_run, bad_run;
  word_class_t word_class;
  logic        data_match;
  logic        good_evt, err_evt;
  logic        frame_good, frame_err;

  tlk2711_word_classify u_classify (
    .word       (word_q),
    .idx        (idx),
    .word_class (word_class),
    .data_match (data_match)
  );

  // Outside sync, stray words in ALIGN are just re-hunting, not link errors.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    good_evt = 1'b0;
    err_evt  = 1'b0;
    case (state)
      ST_HUNT: begin
        if (word_class == WC_COMMA)
          state_nx = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (word_class == WC_SOF) begin
          state_nx = ST_PAYLOAD;
          idx_nx   = 8'd0;
        end else if (word_class != WC_COMMA) begin
          state_nx = ST_HUNT;
          err_evt  = o_sync;
        end
      end
      ST_PAYLOAD: begin
        if (data_match) begin
          if (idx == LAST_IDX) begin
            good_evt = 1'b1;
            state_nx = ST_ALIGN;
            idx_nx   = 8'd0;
          end else begin
            idx_nx = idx + 8'd1;
          end
        end else begin
          err_evt  = 1'b1;
          state_nx = ST_HUNT;
        end
      end
      default: state_nx = ST_HUNT;
    endcase
  end

  assign frame_good = enable_q & good_evt;
  assign frame_err  = enable_q & err_evt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q       <= '0;
      enable_q     <= 1'b0;
      clear_q      <= 1'b0;
      state        <= ST_HUNT;
      idx          <= '0;
      good_run     <= '0;
      bad_run      <= '0;
      o_sync       <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      o_frame_cnt  <= '0;
      o_err_cnt    <= '0;
    end else begin
      word_q   <= {i_rkmsb, i_rklsb, i_rxd};
      enable_q <= i_enable;
      clear_q  <= i_clear;

      if (!enable_q) begin
        state        <= ST_HUNT;
        idx          <= '0;
        good_run     <= '0;
        bad_run      <= '0;
        o_sync       <= 1'b0;
        o_frame_done <= 1'b0;
        o_err        <= 1'b0;
      end else begin
        state        <= state_nx;
        idx          <= idx_nx;
        o_frame_done <= good_evt;
        o_err        <= err_evt;
        if (good_evt) begin
          bad_run <= '0;
          if (good_run != '1)
            good_run <= good_run + 8'd1;
          if (int'(good_run) + 1 >= SYNC_FRAMES)
            o_sync <= 1'b1;
        end
        if (err_evt) begin
          good_run <= '0;
          if (bad_run != '1)
            bad_run <= bad_run + 8'd1;
          if (int'(bad_run) + 1 >= LOSS_FRAMES)
            o_sync <= 1'b0;
        end
      end

      // Clear beats a coincident event so the counters read exactly zero afterwards.
      if (clear_q) begin
        o_frame_cnt <= '0;
        o_err_cnt   <= '0;
      end else begin
        if (frame_good && o_frame_cnt != '1)
          o_frame_cnt <= o_frame_cnt + 32'd1;
        if (frame_err && o_err_cnt != '1)
          o_err_cnt <= o_err_cnt + 16'd1;
      end
    end
  end

`ifdef TLK2711_RX_ERR_LOG_EN
  logic log_valid;

  // Errors seen outside PAYLOAD were waiting for SOF, so that is what was expected.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_q) begin
      log_valid  <= 1'b0;
      o_err_word <= '0;
      o_err_exp  <= '0;
      o_err_idx  <= '0;
    end else if (frame_err && !log_valid) begin
      log_valid  <= 1'b1;
      o_err_word <= word_q;
      o_err_exp  <= (state == ST_PAYLOAD) ? data_word(idx) : SOF_WORD;
      o_err_idx  <= (state == ST_PAYLOAD) ? idx : 8'hFF;
    end
  end
`else
  assign o_err_word = '0;
  assign o_err_exp  = '0;
  assign o_err_idx  = '0;
`endif

endmodule

// File: doc/tlk2711_rx_checker.md
# tlk2711_rx_checker

Receive-side frame checker for the TLK2711 link, running in the recovered `rx_clk` domain on the deserializer's parallel output. It locks onto the transmitter's comma/SOF framing and checks every frame's 32-word incrementing payload. It reports sync status, good-frame and error counts, and per-event pulses. It replaces ILA-only observation of `i_rxd` with a self-checking result readable over VIO/registers.

## Interface
- `DATA_WORDS`, default 32: payload words per frame, 1..256.
- `SYNC_FRAMES`, default 2: consecutive good frames needed to assert sync.
- `LOSS_FRAMES`, default 3: consecutive errored frames needed to drop sync.
- `clk`  in  1: recovered receive clock (`rx_clk` at top level).
- `rst_n`  in  1: synchronous reset, active-low.
- `i_enable`  in  1: checker enable.
- `i_clear`  in  1: synchronous clear of counters and error log.
- `i_rkmsb`  in  1: K flag for `i_rxd[15:8]`.
- `i_rklsb`  in  1: K flag for `i_rxd[7:0]`.
- `i_rxd`  in  16: received word.
- `o_sync`  out  1: frame lock.
- `o_frame_done`  out  1: one-cycle pulse per error-free frame.
- `o_err`  out  1: one-cycle pulse per detected error.
- `o_frame_cnt`  out  32: good frames, saturating.
- `o_err_cnt`  out  16: errors, saturating.
- `o_err_word`, `o_err_exp`  out  18 each: `{rkmsb, rklsb, rxd}` of first error, actual / expected.
- `o_err_idx`  out  8: payload index of first error; 8'hFF if error was outside payload.

## Operation
- Word classes, K flags included in every match:
  - COMMA: `{0,1,16'hC5BC}`.
  - SOF: `{0,1,16'hABBC}`.
  - DATA(n): `{0,0,n[7:0],n[7:0]}`.
  - Anything else: BAD.
- FSM states: HUNT, ALIGN, PAYLOAD.
  - HUNT: COMMA -> ALIGN; all other words ignored, no error.
  - ALIGN: COMMA stays; SOF -> PAYLOAD with idx=0; any other word -> HUNT, and counts an error only if `o_sync`=1.
  - PAYLOAD: word must equal DATA(idx). On match, idx++. On match at idx=DATA_WORDS-1, the frame is good -> ALIGN.
  - PAYLOAD mismatch: error, frame bad -> HUNT. A COMMA received mid-payload is a mismatch.
- Any number (≥1) of commas before SOF is legal, so continuous comma streams (loopback/K-code modes) are accepted silently in ALIGN.
- Sync:
  - A good-frame run counter reaching SYNC_FRAMES sets `o_sync`.
  - A bad-frame run counter reaching LOSS_FRAMES clears it.
  - Each run counter resets on the opposite event.
- `o_frame_cnt` and `o_err_cnt` stick at all-ones.
- `i_enable`=0: FSM forced to HUNT, `o_sync`=0, run counters 0, pulses low, counters and log hold.
- `i_clear`: zeroes `o_frame_cnt`, `o_err_cnt`, and the log (re-arming first-error capture). FSM and sync are untouched. When clear and an event occur in the same cycle, clear wins (count = 0).

## Timing
- Inputs pass through one register stage. The FSM evaluates the registered word.
- A word present before edge E0 affects outputs after E1: 2-cycle latency from pins to pulses, counters and sync.
- `o_frame_done` is high exactly one cycle for the final payload word. `o_err` is high one cycle per error word.
- Back-to-back frames need no gap beyond comma+SOF. The minimum frame is 1 COMMA + SOF + DATA_WORDS words.
- Reset values: all outputs 0, `o_err_idx`=0, FSM=HUNT, idx=0.
- Reset mid-frame aborts it with no pulse.

## Configuration
- Macro `TLK2711_RX_ERR_LOG_EN`.
  - Defined: first error after reset/clear is latched into `o_err_word`, `o_err_exp` and `o_err_idx`, held until `i_clear`.
  - Undefined: capture logic is absent and these three outputs are constant 0. Counters and pulses are unchanged.
- For an error outside the payload, `o_err_exp` = SOF pattern.

## Structure
- Package `tlk2711_pkg`: K28_5 (8'hBC), D5_6 (8'hC5), D11_5 (8'hAB), 18-bit COMMA/SOF word constants, FSM state enum, word-class enum (COMMA/SOF/DATA/BAD). The transmitter is to import the same constants.
- Sub-module `tlk2711_word_classify`: combinational; inputs registered word and expected idx; outputs class and data-match flag.

## Test plan
- Reset, enable; 2 commas, SOF, 0x0000..0x1F1F, repeated 3 times -> 3 `o_frame_done` pulses, `o_frame_cnt`=3, `o_sync`=1 after frame 2, `o_err_cnt`=0.
- 200 consecutive commas, then one frame -> no errors, `o_frame_cnt`=1.
- Locked link; payload word idx 5 corrupted to 0x0505 with `rkmsb`=1 -> `o_err` pulse, `o_err_cnt`=1, `o_err_idx`=5, `o_err_exp`=0x00505; next frame counted good.
- Locked link; 3 consecutive frames each with a bad word -> `o_sync` drops 2 cycles after the third error.
- `i_clear` in the same cycle as an `o_err` pulse -> `o_err_cnt`=0 afterwards; next error latches a new log entry.
- `rst_n` low at payload idx 17 -> all outputs 0; subsequent comma/SOF/frame counted normally.
